sram_tile_reader: RTL

SRAM_TILE_READER -- requirements
Module: sram_tile_reader

---
 rtl/npu_sram_pkg.sv | 19 +
 rtl/stream_fifo2.sv | 59 +++++
 rtl/sram_tile_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/npu_sram_pkg.sv
// Shared sizing and FSM state encoding for the NPU SRAM tile path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npu_sram_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int N_ENTRIES          = 4096;
    localparam int ADDRW              = $clog2(N_ENTRIES);
    localparam int MAX_CHANNELS       = 64;
    localparam int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tile_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO carrying one row (data + last flag) per entry.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: head held until i_pop_rdy; push and pop in one cycle both act, even when full.
//
// Ports: i_clk/i_rst (sync, active-high), i_push_vld/i_push_dat write side,
//        o_pop_vld/o_pop_dat head, i_pop_rdy consumer ready, o_count occupancy (0..2).
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    input  logic             i_pop_rdy,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop_rdy && (r_count != 2'd0);
    // When full, the slot being written is the one leaving this cycle.
    assign w_push = i_push_vld && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: the head is only observed while o_pop_vld is high.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_pop_vld = (r_count != 2'd0);
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/sram_tile_reader.sv
// Reads a rows x channels tile from a multi-lane SRAM and streams one row per beat.
// Latency: start at edge 0 -> SRAM read in cycle 1 -> data back cycle 2 -> out_valid_o cycle 3.
// Backpressure: out_ready_i low stalls the head; reads are throttled so at most 2 rows are outstanding.
//
// Ports: clk_i/rst_i; start_i + base/stride/rows/channels configuration; busy_o/done_o status;
//        sram_* read request (en, we=0, lane count, packed per-lane addresses) and response
//        (sram_data_i, sram_ready_i); out_valid_o/out_ready_i/out_data_o/out_last_o row stream.
module sram_tile_reader #(
    parameter int DATA_WIDTH         = npu_sram_pkg::DATA_WIDTH,
    parameter int N_ENTRIES          = npu_sram_pkg::N_ENTRIES,
    parameter int ADDRW              = $clog2(N_ENTRIES),
    parameter int MAX_CHANNELS       = npu_sram_pkg::MAX_CHANNELS,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
    parameter int ROWW               = 12
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [ADDRW-1:0]                   base_addr_i,
    input  logic [ADDRW-1:0]                   row_stride_i,
    input  logic [ROWW-1:0]                    num_rows_i,
    input  logic [NUM_CHANNELS_WIDTH-1:0]      num_channels_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               sram_en_o,
    output logic                               sram_we_o,
    output logic [NUM_CHANNELS_WIDTH-1:0]      sram_num_channels_o,
    output logic [ADDRW*MAX_CHANNELS-1:0]      sram_addr_o,
    input  logic [DATA_WIDTH*MAX_CHANNELS-1:0] sram_data_i,
    input  logic                               sram_ready_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DATA_WIDTH*MAX_CHANNELS-1:0] out_data_o,
    output logic                               out_last_o
);

    import npu_sram_pkg::*;

    localparam int RWID = DATA_WIDTH * MAX_CHANNELS;

    tile_state_e r_state;
    tile_state_e w_state_nxt;

    logic [ADDRW-1:0]              r_stride;
    logic [ROWW-1:0]               r_rows;
    logic [NUM_CHANNELS_WIDTH-1:0] r_nch;
    logic [ADDRW-1:0]              r_row_addr;
    logic [ROWW-1:0]               r_issue_cnt;
    logic [ROWW-1:0]               r_recv_cnt;
    logic [1:0]                    r_inflight;

    logic [NUM_CHANNELS_WIDTH-1:0] w_nch_clamped;
    logic                          w_zero_cfg;
    logic                          w_rows_left;
    logic                          w_pop;
    logic [2:0]                    w_credit;
    logic                          w_issue;
    logic                          w_last_issue;
    logic                          w_accept;
    logic                          w_recv_last;
    logic [RWID-1:0]               w_push_data;
    logic [ADDRW*MAX_CHANNELS-1:0] w_addr;
    logic                          w_fifo_vld;
    logic [RWID:0]                 w_fifo_head;
    logic [1:0]                    w_fifo_count;
    logic                          w_head_last;

    assign w_nch_clamped = (num_channels_i > NUM_CHANNELS_WIDTH'(MAX_CHANNELS))
                         ? NUM_CHANNELS_WIDTH'(MAX_CHANNELS) : num_channels_i;

    assign w_zero_cfg   = (r_rows == '0) || (r_nch == '0);
    assign w_rows_left  = (r_issue_cnt != r_rows);
    assign w_pop        = w_fifo_vld && out_ready_i;
    // Rows already committed after this cycle's pop: queued plus still in the SRAM pipe.
    assign w_credit     = {1'b0, w_fifo_count} - {2'b00, w_pop} + {1'b0, r_inflight};
    assign w_issue      = (r_state == RUN) && !w_zero_cfg && w_rows_left && (w_credit < 3'd2);
    assign w_last_issue = w_issue && (r_issue_cnt == r_rows - ROWW'(1));
    // A response with nothing in flight is stale (e.g. a read issued just before reset).
    assign w_accept     = sram_ready_i && (r_inflight != 2'd0);
    assign w_recv_last  = (r_recv_cnt == r_rows - ROWW'(1));
    assign w_head_last  = w_fifo_head[RWID];

    always_comb begin
        w_addr      = '0;
        w_push_data = '0;
        for (int c = 0; c < MAX_CHANNELS; c++) begin
            if (c < int'(r_nch)) begin
                w_addr[c*ADDRW +: ADDRW]           = r_row_addr + ADDRW'(c);
                w_push_data[c*DATA_WIDTH +: DATA_WIDTH] = sram_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = RUN;
            RUN: begin
                if (w_zero_cfg) begin
                    w_state_nxt = DONE;
                end else if (w_last_issue) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   if (w_pop && w_head_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stride    <= '0;
            r_rows      <= '0;
            r_nch       <= '0;
            r_row_addr  <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_inflight  <= 2'd0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_stride    <= row_stride_i;
                r_rows      <= num_rows_i;
                r_nch       <= w_nch_clamped;
                r_row_addr  <= base_addr_i;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_row_addr  <= r_row_addr + r_stride;
                    r_issue_cnt <= r_issue_cnt + ROWW'(1);
                end
                if (w_accept) begin
                    r_recv_cnt <= r_recv_cnt + ROWW'(1);
                end
            end
            r_inflight <= r_inflight + {1'b0, w_issue} - {1'b0, w_accept};
        end
    end

    stream_fifo2 #(
        .WIDTH(RWID + 1)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_push_vld (w_accept),
        .i_push_dat ({w_recv_last, w_push_data}),
        .o_pop_vld  (w_fifo_vld),
        .o_pop_dat  (w_fifo_head),
        .i_pop_rdy  (out_ready_i),
        .o_count    (w_fifo_count)
    );

    assign busy_o              = (r_state == RUN) || (r_state == DRAIN);
    assign done_o              = (r_state == DONE);
    assign sram_en_o           = w_issue;
    assign sram_we_o           = 1'b0;
    assign sram_num_channels_o = r_nch;
    assign sram_addr_o         = w_addr;
    assign out_valid_o         = w_fifo_vld;
    assign out_data_o          = w_fifo_vld ? w_fifo_head[RWID-1:0] : '0;
    assign out_last_o          = w_fifo_vld && w_head_last;

endmodule
